// File: rtl/alu_exec_seq.sv
// ALU decode+execute stage with valid/ready handshakes and iterative MULTU/DIVU.
// Optional feature macro: ALU_DIV_EN (adds the restoring divider and DIV state).
`ifndef NAND_F
`define NAND_F 6'h28
`endif

module alu_exec_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       aluop,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             err
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
`ifdef ALU_DIV_EN
      DIV  = 2'd2,
`endif
      DONE = 2'd3
   } state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] op_b;
   logic             accept;
   logic [WIDTH-1:0] sc_res;
   logic             sc_err, dec_mul, dec_div;
   logic [WIDTH:0]   mac;

   assign in_ready  = (state == IDLE);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign zero      = out_valid && (result == '0);

   // {result_hi, result} doubles as the product shift register during MUL
   assign mac = {1'b0, result_hi} + (result[0] ? {1'b0, op_b} : '0);

`ifdef ALU_DIV_EN
   logic [WIDTH:0] dshift, dsub;
   assign dshift = {result_hi, result[WIDTH-1]};
   assign dsub   = dshift - {1'b0, op_b};
`endif

   always_comb begin
      sc_res  = '0;
      sc_err  = 1'b0;
      dec_mul = 1'b0;
      dec_div = 1'b0;
      case (aluop)
         3'b000: sc_res = a + b;
         3'b001: sc_res = a - b;
         3'b010: sc_res = a | b;
         3'b011: sc_res[0] = ($signed(a) < $signed(b));
         3'b100: sc_res = a & b;
         3'b111: begin
            case (funct)
               6'h20:   sc_res = a + b;
               6'h22:   sc_res = a - b;
               6'h24:   sc_res = a & b;
               6'h25:   sc_res = a | b;
               6'h26:   sc_res = a ^ b;
               6'h27:   sc_res = ~(a | b);
               6'h2A:   sc_res[0] = ($signed(a) < $signed(b));
               `NAND_F: sc_res = ~(a & b);
               6'h19:   dec_mul = 1'b1;
`ifdef ALU_DIV_EN
               6'h1B:   dec_div = 1'b1;
`endif
               default: sc_err = 1'b1;
            endcase
         end
         default: sc_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (dec_mul)                 state_nx = MUL;
`ifdef ALU_DIV_EN
               else if (dec_div && b != '0) state_nx = DIV;
`endif
               else                         state_nx = DONE;
            end
         end
         MUL:     if (cnt == CNT_LAST) state_nx = DONE;
`ifdef ALU_DIV_EN
         DIV:     if (cnt == CNT_LAST) state_nx = DONE;
`endif
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         op_b      <= '0;
         result    <= '0;
         result_hi <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt       <= '0;
                  op_b      <= b;
                  err       <= sc_err;
                  result_hi <= '0;
                  if (dec_mul) begin
                     result <= a;
`ifdef ALU_DIV_EN
                  end else if (dec_div) begin
                     if (b == '0) begin
                        result    <= '1;
                        result_hi <= a;
                        err       <= 1'b1;
                     end else begin
                        result <= a;
                     end
`endif
                  end else begin
                     result <= sc_res;
                  end
               end
            end
            MUL: begin
               cnt                 <= cnt + 1'b1;
               {result_hi, result} <= {mac, result[WIDTH-1:1]};
            end
`ifdef ALU_DIV_EN
            // result shifts dividend bits out the top and quotient bits in the bottom
            DIV: begin
               cnt <= cnt + 1'b1;
               if (!dsub[WIDTH]) begin
                  result_hi <= dsub[WIDTH-1:0];
                  result    <= {result[WIDTH-2:0], 1'b1};
               end else begin
                  result_hi <= dshift[WIDTH-1:0];
                  result    <= {result[WIDTH-2:0], 1'b0};
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
